// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - UART receive FIFO handshake bundle with producer/consumer modports
interface uart_rx_fifo_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]         InData;
    logic                     InValid;
    logic                     InReady;
    logic [WIDTH-1:0]         DataOut;
    logic                     DataOutValid;
    logic                     DataOutReady;
    logic [$clog2(DEPTH):0]   Count;
    logic                     OverrunClr;
    logic                     Overrun;

    // Receiver and datapath side: drives bytes in, strobes reads, clears overrun
    modport master (
        output InData,
        output InValid,
        output DataOutReady,
        output OverrunClr,
        input  InReady,
        input  DataOut,
        input  DataOutValid,
        input  Count,
        input  Overrun
    );

    // FIFO side
    modport slave (
        input  InData,
        input  InValid,
        input  DataOutReady,
        input  OverrunClr,
        output InReady,
        output DataOut,
        output DataOutValid,
        output Count,
        output Overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through UART receive FIFO; optional sticky overrun via UART_RX_FIFO_OVERRUN_EN
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic          CLK,
    input  logic          reset_n,
    uart_rx_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Status and handshake qualifiers, all from pre-edge registered state
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        push  = bus.InValid & ~full;
        pop   = bus.DataOutReady & ~empty;
    end

    // Storage array: written on push only, deliberately left unreset
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= bus.InData;
        end
    end

    // Pointers and occupancy; pointer width makes wrap modulo DEPTH implicit
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic overrun_q;

    // Sticky overrun: any byte offered while full sets it; set beats clear
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (bus.InValid & full) begin
            overrun_q <= 1'b1;
        end else if (bus.OverrunClr) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.Overrun = overrun_q;
`else
    logic unused_overrun_clr;

    // Without the overrun feature the clear input has no effect
    assign unused_overrun_clr = bus.OverrunClr;
    assign bus.Overrun        = 1'b0;
`endif

    // Head entry falls through; zero when nothing is stored so stale storage never leaks
    assign bus.DataOut      = empty ? '0 : mem[rd_ptr];
    assign bus.DataOutValid = ~empty;
    assign bus.InReady      = ~full;
    assign bus.Count        = count_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entry count; power of two, 2..256.
REQ-002 SHALL have parameter WIDTH, default 8, meaning data bits per entry.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port InData  input  WIDTH  received byte from UART receiver.
REQ-006 SHALL have port InValid  input  1  receiver byte valid; receiver cannot stall.
REQ-007 SHALL have port InReady  output  1  FIFO can accept; high when not full.
REQ-008 SHALL have port DataOut  output  WIDTH  head entry presented to datapath UART read path.
REQ-009 SHALL have port DataOutValid  output  1  FIFO non-empty; read by datapath as UART status bit.
REQ-010 SHALL have port DataOutReady  input  1  datapath read strobe; pops head.
REQ-011 SHALL have port Count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port OverrunClr  input  1  synchronous clear of Overrun.
REQ-013 SHALL have port Overrun  output  1  sticky dropped-byte flag.

Function
REQ-014 SHALL be first-word-fall-through: DataOut equals the oldest entry whenever DataOutValid is high, with zero-cycle read latency.
REQ-015 SHALL drive DataOut to all-zeros when empty.
REQ-016 SHALL define push = InValid & ~full and pop = DataOutReady & ~empty, both evaluated on pre-edge state.
REQ-017 SHALL write InData at the write pointer and advance it by one on push; pointers wrap modulo DEPTH.
REQ-018 SHALL advance the read pointer by one on pop.
REQ-019 SHALL update Count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-020 SHALL define full as Count==DEPTH and empty as Count==0, and drive InReady = ~full and DataOutValid = ~empty combinationally from registered state.
REQ-021 SHALL drop InValid while full and leave the FIFO unchanged, even when a pop occurs in the same cycle.
REQ-022 SHALL ignore DataOutReady while empty, leaving pointers and Count unchanged.
REQ-023 SHALL honour one pop per cycle while DataOutReady is held high, i.e. back-to-back pops.
REQ-024 SHALL preserve ordering exactly across pointer wrap-around.

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear read pointer, write pointer, Count and Overrun.
REQ-026 SHALL, during and after reset, give DataOutValid=0, InReady=1, DataOut=0, Count=0 and Overrun=0.
REQ-027 SHALL discard all stored entries on reset, including reset asserted mid-operation.
REQ-028 SHALL leave the storage array unreset.
REQ-029 SHALL accept a push on the first rising edge after reset_n deasserts.

Configuration
REQ-030 SHALL use macro UART_RX_FIFO_OVERRUN_EN.
REQ-031 SHALL, when UART_RX_FIFO_OVERRUN_EN is defined, set Overrun on any edge with InValid & full.
REQ-032 SHALL, with the macro defined, clear Overrun on OverrunClr; set wins if both occur on the same edge.
REQ-033 SHALL, with the macro defined, hold Overrun until cleared or reset.
REQ-034 SHALL, when UART_RX_FIFO_OVERRUN_EN is undefined, tie Overrun to 0, ignore OverrunClr and synthesize no overrun register; drop behaviour per REQ-021 is unchanged.

Verification
REQ-035 Bench SHALL cover: reset, then push 0x41,0x42,0x43 on consecutive cycles -> Count=3, DataOut=0x41, DataOutValid=1; three consecutive pops -> 0x41,0x42,0x43 in order, then Count=0, DataOut=0x00.
REQ-036 Bench SHALL cover: DEPTH=8, push 8 bytes 0x00..0x07 -> InReady=0, Count=8; push 0xFF -> dropped, Count=8, Overrun=1 with macro and 0 without; OverrunClr -> Overrun=0.
REQ-037 Bench SHALL cover: Count=4, InValid and DataOutReady high on the same cycle -> Count stays 4, head advances, new byte appended at tail.
REQ-038 Bench SHALL cover: full FIFO, InValid and DataOutReady on the same cycle -> input dropped, Count=7.
REQ-039 Bench SHALL cover: 20 push/pop pairs with DEPTH=8 (pointer wrap) -> output sequence identical to input; DataOutReady while empty -> no state change.
REQ-040 Bench SHALL cover: Count=5, assert reset_n low asynchronously between edges -> Count=0, DataOutValid=0 immediately without waiting for an edge; first push after release -> Count=1.
